down_timer: RTL and testbench

Loadable down-counting timer with one-shot and periodic modes. It pairs with the existing up-counter: the up-counter measures elapsed cycles, and this block generates timeouts and periodic ticks from a programmed cycle count. It is used for watchdogs, strobe generation and delay insertion in datapath control.

---
 rtl/down_timer.sv | 128 ++++++++++++
 tb/tb_down_timer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer
//
// Loadable down-counting timer with one-shot and periodic modes.
//
// Loading a reload value N and starting the timer makes the count walk
// N, N-1, ..., 0. A terminal-count pulse is raised in the count==0 cycle.
// In periodic mode the count then reloads and the pulse repeats every
// N+1 cycles. In one-shot mode the timer parks in DONE.
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous, active-high reset
//   i_load      write i_reload into the reload register
//                 (in IDLE/DONE it also writes the count)
//   i_reload    reload value N (period N+1)
//   i_start     start or restart the countdown from the reload register
//   i_abort     stop immediately and return to IDLE
//   i_pause     level; holds the count while running
//   i_periodic  mode select, captured only when a start is accepted
//   o_count     current count
//   o_running   high while counting (RUN)
//   o_tc        terminal-count pulse
//   o_done      high once a one-shot countdown has expired (DONE)

module down_timer #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_reload,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pause,
    input  logic             i_periodic,
    output logic [WIDTH-1:0] o_count,
    output logic             o_running,
    output logic             o_tc,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             periodic;
    logic             running_q;
    logic             done_q;

    // Commands are resolved in priority order reset > abort > start > load
    // > countdown. A load while running only updates the reload register,
    // so it is seen at the next periodic reload (including one happening
    // on this very edge) or at the next start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            count     <= '0;
            reload    <= '0;
            periodic  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (i_abort) begin
            state     <= IDLE;
            count     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (i_start) begin
            state     <= RUN;
            periodic  <= i_periodic;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            if (i_load) begin
                reload <= i_reload;
                count  <= i_reload;
            end else begin
                count  <= reload;
            end
        end else begin
            if (i_load) begin
                reload <= i_reload;
            end
            case (state)
                IDLE, DONE: begin
                    if (i_load) begin
                        count <= i_reload;
                    end
                end
                RUN: begin
                    if (!i_pause) begin
                        if (count != '0) begin
                            count <= count - ONE;
                        end else if (periodic) begin
                            count <= i_load ? i_reload : reload;
                        end else begin
                            state     <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // The pulse marks a terminal count that is actually processed on the
    // coming edge. A reset, abort or (re)start in the same cycle overrides
    // the countdown, so no pulse is emitted for it.
    assign o_tc = (state == RUN) && !i_pause && (count == '0)
                  && !i_rst && !i_abort && !i_start;

    assign o_count   = count;
    assign o_running = running_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer
//
// Scoreboard bench for down_timer. A driver applies one set of inputs per
// cycle, asks a behavioural model what the outputs should be in that cycle,
// pushes the expectation into a queue and then advances the model over the
// clock edge. A separate monitor pops one expectation per cycle and compares
// it with the DUT. Directed scenarios additionally compare against constant
// count sequences.

module tb_down_timer;

    localparam int WIDTH = 10;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             running;
        logic             done;
        logic             tc;
    } expect_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_load = 1'b0;
    logic [WIDTH-1:0] i_reload = '0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_pause = 1'b0;
    logic             i_periodic = 1'b0;
    logic [WIDTH-1:0] o_count;
    logic             o_running;
    logic             o_tc;
    logic             o_done;

    int n_checks = 0;
    int n_fails  = 0;

    expect_t sb_q[$];

    // Reference model: plain integers and flags describing the timer.
    int m_count    = 0;
    int m_reload   = 0;
    bit m_running  = 1'b0;
    bit m_done     = 1'b0;
    bit m_periodic = 1'b0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_load),
        .i_reload   (i_reload),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_pause    (i_pause),
        .i_periodic (i_periodic),
        .o_count    (o_count),
        .o_running  (o_running),
        .o_tc       (o_tc),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, record the expected outputs for that cycle,
    // then step the model across the edge that consumes those inputs.
    task automatic applyStimulus(input bit rst, input bit load,
                                 input logic [WIDTH-1:0] rel, input bit start,
                                 input bit abort, input bit pause,
                                 input bit periodic);
        expect_t e;
        int      rel_val;
        @(posedge i_clk);
        #1;
        i_rst      = rst;
        i_load     = load;
        i_reload   = rel;
        i_start    = start;
        i_abort    = abort;
        i_pause    = pause;
        i_periodic = periodic;

        rel_val   = int'(rel);
        e.count   = WIDTH'(m_count);
        e.running = m_running;
        e.done    = m_done;
        e.tc      = m_running && !pause && (m_count == 0) && !rst && !abort && !start;
        sb_q.push_back(e);

        if (rst) begin
            m_count = 0; m_reload = 0; m_running = 0; m_done = 0; m_periodic = 0;
        end else if (abort) begin
            m_count = 0; m_running = 0; m_done = 0;
        end else if (start) begin
            if (load) m_reload = rel_val;
            m_count    = m_reload;
            m_periodic = periodic;
            m_running  = 1;
            m_done     = 0;
        end else begin
            if (load) m_reload = rel_val;
            if (!m_running) begin
                if (load) m_count = rel_val;
            end else if (!pause) begin
                if (m_count > 0) m_count = m_count - 1;
                else if (m_periodic) m_count = m_reload;
                else begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end
    endtask

    task automatic idleCycle(input bit pause);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, pause, 1'b0);
    endtask

    // Compare the current cycle's outputs with constants from the scenario.
    task automatic expectOut(input string name, input int cnt, input bit run,
                             input bit done, input bit tc);
        @(negedge i_clk);
        checkOutput({name, ".count"},   32'(o_count),   32'(cnt));
        checkOutput({name, ".running"}, 32'(o_running), 32'(run));
        checkOutput({name, ".done"},    32'(o_done),    32'(done));
        checkOutput({name, ".tc"},      32'(o_tc),      32'(tc));
    endtask

    // Scoreboard monitor: one expectation per cycle, checked mid-cycle.
    initial begin
        expect_t e;
        forever begin
            @(negedge i_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("sb.count",   32'(o_count),   32'(e.count));
                checkOutput("sb.running", 32'(o_running), 32'(e.running));
                checkOutput("sb.done",    32'(o_done),    32'(e.done));
                checkOutput("sb.tc",      32'(o_tc),      32'(e.tc));
            end
        end
    end

    initial begin
        int cnt_seq[8];
        int tc_seq[8];
        int run_seq[8];
        bit r_rst, r_load, r_start, r_abort, r_pause, r_per;
        logic [WIDTH-1:0] r_rel;

        // First edge with reset asserted brings the DUT out of X.
        @(posedge i_clk);

        // Reset held two cycles, then five idle cycles.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idleCycle(1'b0);
            expectOut("reset_idle", 0, 0, 0, 0);
        end

        // One-shot N=3.
        applyStimulus(1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            expectOut("oneshot3", 3 - i, 1, 0, (i == 3));
        end
        idleCycle(1'b0);
        expectOut("oneshot3_done", 0, 0, 1, 0);
        idleCycle(1'b0);
        expectOut("oneshot3_hold", 0, 0, 1, 0);

        // Periodic N=2, pause held for two cycles at count 1.
        applyStimulus(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        cnt_seq = '{2, 1, 1, 1, 0, 2, 1, 0};
        tc_seq  = '{0, 0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            idleCycle(i == 1 || i == 2);
            expectOut("periodic2_pause", cnt_seq[i], 1, 0, tc_seq[i]);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Load while running: periodic N=4, load 1 at count 2.
        applyStimulus(1'b0, 1'b1, 10'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        cnt_seq = '{4, 3, 2, 1, 0, 1, 0, 1};
        tc_seq  = '{0, 0, 0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i == 2), 10'd1, 1'b0, 1'b0, 1'b0, 1'b0);
            expectOut("load_in_run", cnt_seq[i], 1, 0, tc_seq[i]);
        end

        // Abort and start together: abort wins.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        idleCycle(1'b0);
        expectOut("abort_start", 0, 0, 0, 0);

        // Start and load together: new value used directly.
        applyStimulus(1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        expectOut("start_load7", 7, 1, 0, 0);

        // Restart at count 1 with N=5: no pulse, count back to 5.
        applyStimulus(1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt_seq = '{5, 4, 3, 2, 1, 5, 4, 3};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, '0, (i == 4), 1'b0, 1'b0, 1'b0);
            expectOut("restart5", cnt_seq[i], 1, 0, 0);
        end

        // Reload 0 periodic: pulse every cycle until abort.
        applyStimulus(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            expectOut("periodic0", 0, 1, 0, 1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        expectOut("periodic0_abort_cycle", 0, 1, 0, 0);
        idleCycle(1'b0);
        expectOut("periodic0_after_abort", 0, 0, 0, 0);

        // Reload 0 one-shot: pulse in the first running cycle, then DONE.
        applyStimulus(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        expectOut("oneshot0", 0, 1, 0, 1);
        idleCycle(1'b0);
        expectOut("oneshot0_done", 0, 0, 1, 0);

        // Reset in the middle of a periodic N=0 run: no pulse in or after it.
        applyStimulus(1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectOut("reset_mid_run", 0, 1, 0, 0);
        idleCycle(1'b0);
        expectOut("after_reset", 0, 0, 0, 0);

        // Full-width reload counts down without wrapping.
        applyStimulus(1'b0, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        expectOut("max_reload", 1023, 1, 0, 0);
        idleCycle(1'b0);
        expectOut("max_reload_dec", 1022, 1, 0, 0);

        // Randomised traffic, checked only through the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            r_rst   = ($urandom_range(0, 149) == 0);
            r_abort = ($urandom_range(0, 39) == 0);
            r_start = ($urandom_range(0, 11) == 0);
            r_load  = ($urandom_range(0, 9) == 0);
            r_pause = ($urandom_range(0, 3) == 0);
            r_per   = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0)
                r_rel = WIDTH'($urandom_range(0, 1023));
            else
                r_rel = WIDTH'($urandom_range(0, 6));
            applyStimulus(r_rst, r_load, r_rel, r_start, r_abort, r_pause, r_per);
        end

        // Let the monitor drain the last expectation.
        @(negedge i_clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
